// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, rx state encoding and bit-timing helper
package uart_pkg;

  localparam int DEF_BASE_FREQ = 50_000_000;
  localparam int DEF_BAUDRATE  = 115_200;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'b000,
    RX_START  = 3'b001,
    RX_DATA   = 3'b010,
    RX_PARITY = 3'b011,
    RX_STOP   = 3'b100
  } rx_state_e;

  function automatic int counts_per_bit(input int base_freq, input int baudrate);
    return base_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for an asynchronous pin, resets to 1 (idle high)
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8E1 UART receiver with centre sampling and parity/framing flags.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BASE_FREQ = DEF_BASE_FREQ,
  parameter int BAUDRATE  = DEF_BAUDRATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CPB  = counts_per_bit(BASE_FREQ, BAUDRATE);
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB) + 1;

  rx_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;

  logic          line_s;
  logic          sample_bit;
  logic          at_adv;
  logic [CW-1:0] adv_cnt;

  uart_sync2 u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (serial_in),
    .sync_o  (line_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Advance one count after the centre; data bits use centre CPB-2 so each bit stays CPB long.
  localparam logic [CW-1:0] START_ADV = CW'(HALF + 1);
  localparam logic [CW-1:0] BIT_ADV   = CW'(CPB - 1);

  logic [1:0] smp_q;
  logic       in_window;

  assign in_window = (state_q != RX_IDLE) &&
                     ((cnt_q == adv_cnt - CW'(2)) || (cnt_q == adv_cnt - CW'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_q <= 2'b11;
    end else if (in_window) begin
      smp_q <= {smp_q[0], line_s};
    end
  end

  assign sample_bit = (smp_q[1] & smp_q[0]) | (smp_q[1] & line_s) | (smp_q[0] & line_s);
`else
  localparam logic [CW-1:0] START_ADV = CW'(HALF);
  localparam logic [CW-1:0] BIT_ADV   = CW'(CPB - 1);

  assign sample_bit = line_s;
`endif

  assign adv_cnt = (state_q == RX_START) ? START_ADV : BIT_ADV;
  assign at_adv  = (cnt_q == adv_cnt);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!line_s) state_d = RX_START;
      end
      RX_START: begin
        if (at_adv) begin
          cnt_d   = '0;
          state_d = sample_bit ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (at_adv) begin
          cnt_d          = '0;
          shift_d[idx_q] = sample_bit;
          if (idx_q == 3'd7) begin
            state_d = RX_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (at_adv) begin
          cnt_d   = '0;
          perr_d  = sample_bit ^ (^shift_q);
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving mid stop bit lets IDLE catch a back-to-back start edge.
        if (at_adv) begin
          cnt_d        = '0;
          rx_data_d    = shift_q;
          parity_err_d = perr_q;
          frame_err_d  = ~sample_bit;
          rx_valid_d   = 1'b1;
          state_d      = RX_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;

  localparam int CPB  = 50_000_000 / 115_200;
  localparam int IDLE = 600;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   long_valid = 0;
  logic prev_valid = 1'b0;
  rec_t obs_q[$];
  rec_t exp_q[$];

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) obs_q.push_back('{d: rx_data, pe: parity_err, fe: frame_err});
    if (rx_valid && prev_valid) long_valid++;
    prev_valid = rx_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8E1 frame; a low stop bit is held only part of a bit so the follow-on start re-check fails.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    serial_in = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      wait_clk(CPB);
    end
    serial_in = p;
    wait_clk(CPB);
    serial_in = stop;
    wait_clk(stop ? CPB : 300);
    serial_in = 1'b1;
  endtask

  function automatic rec_t model(input logic [7:0] d, input logic p, input logic stop);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return '{d: d, pe: ((ones + p) % 2) != 0, fe: !stop};
  endfunction

  task automatic test_reset;
    wait_clk(3);
    chk_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else pass_cnt++;
    chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else pass_cnt++;
    chk_cnt++; if (parity_err !== 1'b0) $display("FAIL reset_parity_err: got %b expected 0", parity_err); else pass_cnt++;
    chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else pass_cnt++;
    chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); else pass_cnt++;
    rst = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_frames;
    logic [7:0] dt [3] = '{8'hA5, 8'h07, 8'h3C};
    logic       pt [3] = '{1'b0, 1'b0, 1'b0};
    logic       st [3] = '{1'b1, 1'b1, 1'b0};
    rec_t e, g;
    for (int k = 0; k < 3; k++) begin
      obs_q.delete();
      e = model(dt[k], pt[k], st[k]);
      send_frame(dt[k], pt[k], st[k]);
      wait_clk(IDLE);
      g = (obs_q.size() > 0) ? obs_q[0] : 'x;
      chk_cnt++; if (obs_q.size() !== 1) $display("FAIL frame%0d_pulses: got %0d expected 1", k, obs_q.size()); else pass_cnt++;
      chk_cnt++; if (g.d !== e.d) $display("FAIL frame%0d_data: got %h expected %h", k, g.d, e.d); else pass_cnt++;
      chk_cnt++; if (g.pe !== e.pe) $display("FAIL frame%0d_parity_err: got %b expected %b", k, g.pe, e.pe); else pass_cnt++;
      chk_cnt++; if (g.fe !== e.fe) $display("FAIL frame%0d_frame_err: got %b expected %b", k, g.fe, e.fe); else pass_cnt++;
      chk_cnt++; if (rx_data !== e.d) $display("FAIL frame%0d_data_held: got %h expected %h", k, rx_data, e.d); else pass_cnt++;
    end
  endtask

  task automatic test_glitch;
    int n = 0;
    obs_q.delete();
    serial_in = 1'b0;
    wait_clk(100);
    chk_cnt++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy_high: got %b expected 1", rx_busy); else pass_cnt++;
    serial_in = 1'b1;
    while (rx_busy === 1'b1 && n < 220) begin
      wait_clk(1);
      n++;
    end
    chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_return: got %b expected 0 within 220 clks", rx_busy); else pass_cnt++;
    wait_clk(IDLE);
    chk_cnt++; if (obs_q.size() !== 0) $display("FAIL glitch_no_valid: got %0d pulses expected 0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    rec_t g;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(model(8'h00, 1'b0, 1'b1));
    exp_q.push_back(model(8'hFF, 1'b0, 1'b1));
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_clk(IDLE);
    chk_cnt++; if (obs_q.size() !== 2) $display("FAIL b2b_pulses: got %0d expected 2", obs_q.size()); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      g = (obs_q.size() > k) ? obs_q[k] : 'x;
      chk_cnt++; if (g !== exp_q[k]) $display("FAIL b2b_frame%0d: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b", k, g.d, g.pe, g.fe, exp_q[k].d, exp_q[k].pe, exp_q[k].fe); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d = 8'h96;
    rec_t e, g;
    obs_q.delete();
    serial_in = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 4; i++) begin
      serial_in = d[i];
      wait_clk(CPB);
    end
    serial_in = d[4];
    wait_clk(200);
    chk_cnt++; if (rx_busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", rx_busy); else pass_cnt++;
    rst = 1'b0;
    #2;
    chk_cnt++; if (rx_busy !== 1'b0) $display("FAIL midrst_busy_async: got %b expected 0", rx_busy); else pass_cnt++;
    serial_in = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(IDLE);
    chk_cnt++; if (obs_q.size() !== 0) $display("FAIL midrst_no_valid: got %0d pulses expected 0", obs_q.size()); else pass_cnt++;
    e = model(8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_clk(IDLE);
    g = (obs_q.size() > 0) ? obs_q[0] : 'x;
    chk_cnt++; if (obs_q.size() !== 1) $display("FAIL midrst_after_pulses: got %0d expected 1", obs_q.size()); else pass_cnt++;
    chk_cnt++; if (g !== e) $display("FAIL midrst_after_frame: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b", g.d, g.pe, g.fe, e.d, e.pe, e.fe); else pass_cnt++;
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic       p, stop;
    rec_t       e, g;
    for (int k = 0; k < 6; k++) begin
      obs_q.delete();
      d    = 8'($urandom);
      p    = ^d ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 3) != 0);
      e    = model(d, p, stop);
      send_frame(d, p, stop);
      wait_clk(IDLE);
      g = (obs_q.size() > 0) ? obs_q[0] : 'x;
      chk_cnt++; if (obs_q.size() !== 1) $display("FAIL rand%0d_pulses: got %0d expected 1", k, obs_q.size()); else pass_cnt++;
      chk_cnt++; if (g !== e) $display("FAIL rand%0d_frame: got d=%h pe=%b fe=%b expected d=%h pe=%b fe=%b", k, g.d, g.pe, g.fe, e.d, e.pe, e.fe); else pass_cnt++;
    end
  endtask

  task automatic test_valid_width;
    chk_cnt++; if (long_valid !== 0) $display("FAIL valid_one_cycle: got %0d multi-cycle pulses expected 0", long_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_valid_width();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
